// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter: opcodes and FSM states.
package logic_unit_arbiter_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_unit_arbiter_rr_arb2.sv
// Two-input round-robin winner select; on a tie the requester that was not served last wins.
module rr_arb2
    import logic_unit_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last,
    output logic       winner,
    output logic       any_valid
);

    always_comb begin
        any_valid = |valid;
        if (&valid) begin
            winner = ~last;
        end else begin
            winner = valid[1];
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one combinational logic unit between two valid/ready requesters, one operation at a time.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic             lu_s1,
    output logic             lu_s0,
    input  logic [WIDTH-1:0] lu_result,
    output logic             busy,
    output logic             grant_id,
    output logic [CNT_W-1:0] ops_done
);

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             win;
    logic             any_vld;
    logic             accept;
    logic             rsp_fire;
    logic [WIDTH-1:0] res_p1;

    rr_arb2 u_arb (
        .valid     ({req1_valid, req0_valid}),
        .last      (last),
        .winner    (win),
        .any_valid (any_vld)
    );

    // Handshakes are masked while rst is high so nothing is offered during reset.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst && any_vld) begin
                    req0_ready = ~win;
                    req1_ready = win;
                    accept     = 1'b1;
                    state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (!rst) begin
                    rsp0_valid = ~grant_id;
                    rsp1_valid = grant_id;
                    rsp_fire   = grant_id ? rsp1_ready : rsp0_ready;
                end
                if (rsp_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage p0: operands into the unit; stage p1: unit output captured for the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            lu_a     <= '0;
            lu_b     <= '0;
            lu_s1    <= 1'b0;
            lu_s0    <= 1'b0;
            grant_id <= 1'b0;
            res_p1   <= '0;
            ops_done <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lu_a     <= win ? req1_a : req0_a;
                lu_b     <= win ? req1_b : req0_b;
                lu_s1    <= win ? req1_op[1] : req0_op[1];
                lu_s0    <= win ? req1_op[0] : req0_op[0];
                grant_id <= win;
            end
            if (state == ST_EXEC) begin
                res_p1 <= lu_result;
            end
            if (rsp_fire) begin
                last     <= grant_id;
                ops_done <= ops_done + CNT_W'(1);
            end
        end
    end

    assign rsp0_data = res_p1;
    assign rsp1_data = res_p1;
    assign busy      = (state != ST_IDLE);

endmodule
